// File: rtl/pico_axis_packer.sv
// pico_axis_packer
//   Packs the PicoBlaze controller's byte stream little-endian into
//   DATA_BYTES-wide words. Completed words go into a small FWFT FIFO that is
//   presented as an AXI4-Stream master.
//
//   Optional build macro PACKER_FLUSH_TIMEOUT_EN:
//     When defined, a partial word that sits idle for FLUSH_CYCLES cycles is
//     pushed out with tlast=0.
//     When undefined, a partial word waits indefinitely for more bytes or in_last.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   in_byte/in_valid/in_last   byte input with strobe and end-of-packet
//   m_axis_*          AXI4-Stream master (tdata byte 0 in [7:0])
//   full, level       FIFO status (registered)
//   overflow          sticky "a word was dropped"
//   clr_overflow      single-cycle clear of overflow
module pico_axis_packer #(
  parameter int DATA_BYTES   = 4,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int FLUSH_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_byte,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic [8*DATA_BYTES-1:0] m_axis_tdata,
  output logic [DATA_BYTES-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    full,
  output logic [ADDR_W:0]         level,
  output logic                    overflow,
  input  logic                    clr_overflow
);
  localparam int DW = 8*DATA_BYTES;
  localparam int BW = $clog2(DATA_BYTES);

  typedef struct packed {
    logic                  last;
    logic [DATA_BYTES-1:0] keep;
    logic [DW-1:0]         data;
  } word_t;

  logic [DATA_BYTES-1:0][7:0] r_lanes;
  logic [BW-1:0]              r_bcnt;
  word_t                      r_mem [DEPTH];
  logic [ADDR_W-1:0]          r_wptr, r_rptr;
  logic [ADDR_W:0]            r_count;
  logic                       r_full, r_ovf;

  word_t           w_word, w_head;
  logic            w_push, w_accept, w_pop, w_flush;
  logic [ADDR_W:0] w_cnt_nxt;

`ifdef PACKER_FLUSH_TIMEOUT_EN
  localparam int IW = $clog2(FLUSH_CYCLES+1);
  logic [IW-1:0] r_idle;

  // Fires on the FLUSH_CYCLES-th consecutive idle edge with a partial word held.
  assign w_flush = !in_valid && (r_bcnt != '0) && (r_idle == IW'(FLUSH_CYCLES-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_idle <= '0;
    else if (in_valid || r_bcnt == '0 || w_flush) r_idle <= '0;
    else                                          r_idle <= r_idle + 1'b1;
  end
`else
  assign w_flush = 1'b0;
`endif

  // Word being completed this edge: held lanes plus the incoming byte.
  // Lanes above bcnt are already zero because r_lanes is cleared on every push.
  always_comb begin
    w_word = '0;
    w_push = 1'b0;
    for (int i = 0; i < DATA_BYTES; i++)
      w_word.data[8*i +: 8] = (in_valid && int'(r_bcnt) == i) ? in_byte : r_lanes[i];
    if (in_valid) begin
      w_word.keep = DATA_BYTES'((32'd1 << (int'(r_bcnt) + 1)) - 32'd1);
      w_word.last = in_last;
      w_push      = (int'(r_bcnt) == DATA_BYTES-1) || in_last;
    end else if (w_flush) begin
      w_word.keep = DATA_BYTES'((32'd1 << int'(r_bcnt)) - 32'd1);
      w_word.last = 1'b0;
      w_push      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lanes <= '0;
      r_bcnt  <= '0;
    end else if (w_push) begin
      // Dropped or accepted, the packer always starts a fresh word.
      r_lanes <= '0;
      r_bcnt  <= '0;
    end else if (in_valid) begin
      r_lanes[r_bcnt] <= in_byte;
      r_bcnt          <= r_bcnt + 1'b1;
    end
  end

  // Space is judged on the count before the edge; a same-edge pop does not help.
  assign w_accept = w_push && !r_full;
  assign w_pop    = (r_count != '0) && m_axis_tready;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_accept, w_pop})
      2'b10:   w_cnt_nxt = r_count + 1'b1;
      2'b01:   w_cnt_nxt = r_count - 1'b1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (ADDR_W+1)'(DEPTH));
      // A drop on the same edge as a clear keeps the flag set.
      if (w_push && !w_accept) r_ovf <= 1'b1;
      else if (clr_overflow)   r_ovf <= 1'b0;
    end
  end

  // Storage is not reset; gating on an empty FIFO keeps outputs at 0 after reset.
  assign w_head        = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign m_axis_tdata  = w_head.data;
  assign m_axis_tkeep  = w_head.keep;
  assign m_axis_tlast  = w_head.last;
  assign m_axis_tvalid = (r_count != '0);
  assign full          = r_full;
  assign level         = r_count;
  assign overflow      = r_ovf;
endmodule

// File: tb/tb_pico_axis_packer.sv
// Directed bench for pico_axis_packer (DATA_BYTES=4, DEPTH=16, FLUSH_CYCLES=10).
module tb_pico_axis_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        full;
  logic [4:0]  level;
  logic        overflow;
  logic        clr_overflow = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  pico_axis_packer #(.DATA_BYTES(4), .DEPTH(16), .ADDR_W(4), .FLUSH_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .full(full), .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    tick(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send(w[8*j +: 8], 1'b0);
  endtask

  function automatic logic [31:0] w3(input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(k*4 + j + 1);
    return w;
  endfunction

  initial begin
    // Reset state
    tick(2);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("rst_tkeep",  64'(m_axis_tkeep),  64'd0);
    chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
    chk("rst_full",   64'(full),          64'd0);
    chk("rst_level",  64'(level),         64'd0);
    chk("rst_ovf",    64'(overflow),      64'd0);
    reset = 1'b0;
    tick(1);

    // 1: full word, tready=1
    m_axis_tready = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    chk("t1_pre_tvalid", 64'(m_axis_tvalid), 64'd0);
    send(8'h44, 0);
    chk("t1_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t1_tdata",  64'(m_axis_tdata),  64'h44332211);
    chk("t1_tkeep",  64'(m_axis_tkeep),  64'hF);
    chk("t1_tlast",  64'(m_axis_tlast),  64'd0);
    chk("t1_level",  64'(level),         64'd1);
    tick(1);
    chk("t1_tvalid_off", 64'(m_axis_tvalid), 64'd0);
    chk("t1_level0",     64'(level),         64'd0);

    // 2: short packet
    send(8'hAA, 0); send(8'hBB, 1);
    chk("t2_tdata", 64'(m_axis_tdata), 64'h0000BBAA);
    chk("t2_tkeep", 64'(m_axis_tkeep), 64'h3);
    chk("t2_tlast", 64'(m_axis_tlast), 64'd1);
    tick(1);
    chk("t2_level0", 64'(level), 64'd0);

    // in_last with bcnt=0: single-byte word
    m_axis_tready = 1'b0;
    send(8'h7E, 1);
    chk("t2b_tdata", 64'(m_axis_tdata), 64'h7E);
    chk("t2b_tkeep", 64'(m_axis_tkeep), 64'h1);
    chk("t2b_tlast", 64'(m_axis_tlast), 64'd1);
    m_axis_tready = 1'b1;
    tick(1);
    chk("t2b_level0", 64'(level), 64'd0);

    // 3: fill, overflow, clear, drain
    m_axis_tready = 1'b0;
    for (int k = 0; k < 16; k++) send_word(w3(k));
    chk("t3_full",   64'(full),     64'd1);
    chk("t3_level",  64'(level),    64'd16);
    chk("t3_ovf0",   64'(overflow), 64'd0);
    send_word(w3(16));
    chk("t3_ovf1",   64'(overflow), 64'd1);
    chk("t3_level2", 64'(level),    64'd16);
    chk("t3_head",   64'(m_axis_tdata), 64'(w3(0)));
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("t3_ovf_clr", 64'(overflow), 64'd0);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t3_drain_vld",  64'(m_axis_tvalid), 64'd1);
      chk("t3_drain_data", 64'(m_axis_tdata),  64'(w3(k)));
      tick(1);
    end
    chk("t3_empty_vld", 64'(m_axis_tvalid), 64'd0);
    chk("t3_empty_lvl", 64'(level),         64'd0);
    chk("t3_empty_full", 64'(full),         64'd0);

    // 4: simultaneous push and pop at level 1
    m_axis_tready = 1'b0;
    send_word(32'hA4A3A2A1);
    chk("t4_level1", 64'(level), 64'd1);
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0);
    chk("t4_head_hold", 64'(m_axis_tdata), 64'hA4A3A2A1);
    m_axis_tready = 1'b1;
    send(8'hB4, 0);
    chk("t4_level_same", 64'(level),        64'd1);
    chk("t4_next_data",  64'(m_axis_tdata), 64'hB4B3B2B1);
    tick(1);
    chk("t4_level0", 64'(level), 64'd0);

    // 5: async reset mid-packet with 3 words stored
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(w3(k));
    send(8'hC1, 0); send(8'hC2, 0);
    chk("t5_pre_level", 64'(level), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_rst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("t5_rst_tkeep",  64'(m_axis_tkeep),  64'd0);
    chk("t5_rst_level",  64'(level),         64'd0);
    tick(1);
    reset = 1'b0;
    m_axis_tready = 1'b1;
    tick(1);
    chk("t5_post_level", 64'(level), 64'd0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    chk("t5_tdata", 64'(m_axis_tdata), 64'h04030201);
    chk("t5_tkeep", 64'(m_axis_tkeep), 64'hF);
    chk("t5_level", 64'(level),        64'd1);
    tick(1);
    chk("t5_only_one", 64'(m_axis_tvalid), 64'd0);

    // 6: idle partial word; in_last held high without in_valid must be ignored
    m_axis_tready = 1'b0;
    send(8'h5A, 0);
    in_last = 1'b1;
`ifdef PACKER_FLUSH_TIMEOUT_EN
    tick(9);
    chk("t6_no_flush_yet", 64'(m_axis_tvalid), 64'd0);
    tick(1);
    chk("t6_flush_vld",  64'(m_axis_tvalid), 64'd1);
    chk("t6_flush_data", 64'(m_axis_tdata),  64'h5A);
    chk("t6_flush_keep", 64'(m_axis_tkeep),  64'h1);
    chk("t6_flush_last", 64'(m_axis_tlast),  64'd0);
`else
    tick(100);
    chk("t6_no_word_vld", 64'(m_axis_tvalid), 64'd0);
    chk("t6_no_word_lvl", 64'(level),         64'd0);
`endif
    in_last = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
